// File: rtl/ascon_ctrl.sv
// ascon_ctrl: sequencing FSM for the ASCON-128 encryption datapath (control only, no state data).
// Optional abort input enabled by defining ASCON_ABORT_EN.
module ascon_ctrl #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
`ifdef ASCON_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       init_state_o,
    output logic       ena_perm_o,
    output logic [3:0] round_o,
    output logic       ena_xor_up_o,
    output logic       sel_up_o,
    output logic       ena_xor_down_o,
    output logic       sel_down_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FIN, DONE} state_t;

    localparam logic [7:0] AD_LAST = 8'(NB_AD_BLOCKS - 1);
    localparam logic [7:0] PT_LAST = 8'(NB_PT_BLOCKS - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_round;
    logic [7:0] r_ad_cnt, r_pt_cnt;
    logic       w_abort, w_xfer, w_r11, w_ad_last, w_pt_last;

`ifdef ASCON_ABORT_EN
    assign w_abort = abort_i && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_xfer    = data_valid_i && !w_abort;
    assign w_r11     = r_round == 4'd11;
    assign w_ad_last = r_ad_cnt == AD_LAST;
    assign w_pt_last = r_pt_cnt == PT_LAST;

    always_comb begin
        w_state_nxt    = r_state;
        data_ready_o   = 1'b0;
        init_state_o   = 1'b0;
        ena_perm_o     = 1'b0;
        round_o        = r_round;
        ena_xor_up_o   = 1'b0;
        sel_up_o       = 1'b0;
        ena_xor_down_o = 1'b0;
        sel_down_o     = 1'b0;
        cipher_valid_o = 1'b0;
        tag_valid_o    = 1'b0;
        busy_o         = r_state != IDLE;
        case (r_state)
            IDLE: w_state_nxt = start_i ? INIT : IDLE;
            INIT: begin
                ena_perm_o     = 1'b1;
                init_state_o   = r_round == 4'd0;
                ena_xor_down_o = w_r11;
                w_state_nxt    = w_r11 ? AD_WAIT : INIT;
            end
            AD_WAIT: begin
                // The accepted block is absorbed during round 6 itself, so waiting just parks at 6.
                data_ready_o = !w_abort;
                round_o      = 4'd6;
                ena_perm_o   = w_xfer;
                ena_xor_up_o = w_xfer;
                w_state_nxt  = w_xfer ? AD_PERM : AD_WAIT;
            end
            AD_PERM: begin
                ena_perm_o     = 1'b1;
                ena_xor_down_o = w_r11 && w_ad_last;
                sel_down_o     = w_r11 && w_ad_last;
                w_state_nxt    = !w_r11 ? AD_PERM : w_ad_last ? PT_WAIT : AD_WAIT;
            end
            PT_WAIT: begin
                // The last block starts the 12-round finalisation, so it enters at round 0.
                data_ready_o   = !w_abort;
                round_o        = w_pt_last ? 4'd0 : 4'd6;
                ena_perm_o     = w_xfer;
                ena_xor_up_o   = w_xfer;
                sel_up_o       = w_xfer && w_pt_last;
                cipher_valid_o = w_xfer;
                w_state_nxt    = !w_xfer ? PT_WAIT : w_pt_last ? FIN : PT_PERM;
            end
            PT_PERM: begin
                ena_perm_o  = 1'b1;
                w_state_nxt = w_r11 ? PT_WAIT : PT_PERM;
            end
            FIN: begin
                ena_perm_o     = 1'b1;
                ena_xor_down_o = w_r11;
                w_state_nxt    = w_r11 ? DONE : FIN;
            end
            DONE: begin
                tag_valid_o = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt    = IDLE;
            cipher_valid_o = 1'b0;
            tag_valid_o    = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state  <= IDLE;
            r_round  <= 4'd0;
            r_ad_cnt <= 8'd0;
            r_pt_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_abort ? 4'd0 : !ena_perm_o ? r_round : (round_o == 4'd11) ? 4'd0 : round_o + 4'd1;
            if (w_abort || (r_state == IDLE && start_i)) begin
                r_ad_cnt <= 8'd0;
                r_pt_cnt <= 8'd0;
            end else begin
                if (r_state == AD_PERM && w_r11)
                    r_ad_cnt <= r_ad_cnt + 8'd1;
                if (r_state == PT_PERM && w_r11)
                    r_pt_cnt <= r_pt_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: checks ascon_ctrl (default 1/4 blocks and a 2/1 variant) against a per-cycle expected timeline.
module tb_ascon_ctrl;
    typedef struct packed {
        logic        st;
        logic        v;
        logic [13:0] o;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb = 1'b0;
    logic st0 = 1'b0, v0 = 1'b0, st1 = 1'b0, v1 = 1'b0;
    logic rdy0, init0, perm0, up0, sup0, dn0, sdn0, cv0, tv0, busy0;
    logic rdy1, init1, perm1, up1, sup1, dn1, sdn1, cv1, tv1, busy1;
    logic [3:0] rnd0, rnd1;
    logic [13:0] o0, o1;
`ifdef ASCON_ABORT_EN
    logic ab0 = 1'b0, ab1 = 1'b0;
`endif

    assign o0 = {rdy0, init0, perm0, rnd0, up0, sup0, dn0, sdn0, cv0, tv0, busy0};
    assign o1 = {rdy1, init1, perm1, rnd1, up1, sup1, dn1, sdn1, cv1, tv1, busy1};

    ascon_ctrl #(.NB_AD_BLOCKS(1), .NB_PT_BLOCKS(4)) dut0 (
        .clock_i(clk), .resetb_i(rstb), .start_i(st0),
`ifdef ASCON_ABORT_EN
        .abort_i(ab0),
`endif
        .data_valid_i(v0), .data_ready_o(rdy0), .init_state_o(init0), .ena_perm_o(perm0),
        .round_o(rnd0), .ena_xor_up_o(up0), .sel_up_o(sup0), .ena_xor_down_o(dn0),
        .sel_down_o(sdn0), .cipher_valid_o(cv0), .tag_valid_o(tv0), .busy_o(busy0)
    );

    ascon_ctrl #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rstb), .start_i(st1),
`ifdef ASCON_ABORT_EN
        .abort_i(ab1),
`endif
        .data_valid_i(v1), .data_ready_o(rdy1), .init_state_o(init1), .ena_perm_o(perm1),
        .round_o(rnd1), .ena_xor_up_o(up1), .sel_up_o(sup1), .ena_xor_down_o(dn1),
        .sel_down_o(sdn1), .cipher_valid_o(cv1), .tag_valid_o(tv1), .busy_o(busy1)
    );

    int   checks = 0;
    int   errors = 0;
    int   stall_sum;
    rec_t q[$];

    function automatic rec_t mk(input logic st, v, rdy, init, perm, input logic [3:0] rnd,
                                input logic up, sup, dn, sdn, cv, tv, busy);
        return {st, v, rdy, init, perm, rnd, up, sup, dn, sdn, cv, tv, busy};
    endfunction

    function automatic logic nz(input bit en);
        return en && ($urandom_range(0, 1) == 1);
    endfunction

    // Expected behaviour as a flat list of cycles: start, 12 init rounds, AD blocks, PT blocks, finalisation, tag.
    task automatic build(input int nad, input int npt, input int ad_stall0, input int max_stall, input bit noise);
        int  s;
        bit  last;
        logic [3:0] wr;
        q.delete();
        stall_sum = 0;
        q.push_back(mk(1, nz(noise), 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < 12; r++)
            q.push_back(mk(nz(noise), nz(noise), 0, r == 0, 1, 4'(r), 0, 0, r == 11, 0, 0, 0, 1));
        for (int a = 0; a < nad; a++) begin
            s = (a == 0) ? ad_stall0 : int'($urandom_range(0, max_stall));
            stall_sum += s;
            repeat (s) q.push_back(mk(nz(noise), 0, 1, 0, 0, 4'd6, 0, 0, 0, 0, 0, 0, 1));
            q.push_back(mk(nz(noise), 1, 1, 0, 1, 4'd6, 1, 0, 0, 0, 0, 0, 1));
            for (int r = 7; r < 12; r++) begin
                last = (r == 11) && (a == nad - 1);
                q.push_back(mk(nz(noise), nz(noise), 0, 0, 1, 4'(r), 0, 0, last, last, 0, 0, 1));
            end
        end
        for (int p = 0; p < npt; p++) begin
            last = p == npt - 1;
            wr = last ? 4'd0 : 4'd6;
            s = $urandom_range(0, max_stall);
            stall_sum += s;
            repeat (s) q.push_back(mk(nz(noise), 0, 1, 0, 0, wr, 0, 0, 0, 0, 0, 0, 1));
            q.push_back(mk(nz(noise), 1, 1, 0, 1, wr, 1, last, 0, 0, 1, 0, 1));
            if (!last)
                for (int r = 7; r < 12; r++)
                    q.push_back(mk(nz(noise), nz(noise), 0, 0, 1, 4'(r), 0, 0, 0, 0, 0, 0, 1));
        end
        for (int r = 1; r < 12; r++)
            q.push_back(mk(nz(noise), nz(noise), 0, 0, 1, 4'(r), 0, 0, r == 11, 0, 0, 0, 1));
        q.push_back(mk(nz(noise), nz(noise), 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 1));
        q.push_back(mk(0, nz(noise), 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input string name, input int dut, input int stop_at, output int tag_at);
        logic [13:0] got;
        tag_at = -1;
        for (int i = 0; i < q.size() && i < stop_at; i++) begin
            @(negedge clk);
            st0 = (dut == 0) ? q[i].st : 1'b0;
            v0  = (dut == 0) ? q[i].v  : 1'b0;
            st1 = (dut == 1) ? q[i].st : 1'b0;
            v1  = (dut == 1) ? q[i].v  : 1'b0;
            #1;
            got = (dut == 0) ? o0 : o1;
            checks++;
            if (got !== q[i].o) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b", name, i, got, q[i].o);
            end
            if (got[1] === 1'b1 && tag_at < 0) tag_at = i;
        end
    endtask

    task automatic check_lat(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s latency: tag at %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o0 !== 14'd0 || o1 !== 14'd0) begin
            errors++;
            $display("FAIL %s: outputs %b / %b, expected all zero", name, o0, o1);
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check_idle("reset_hold");
        end
        rstb = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check_idle("reset_idle");
        end
    endtask

    task automatic test_nominal;
        int t;
        build(1, 4, 0, 0, 0);
        run("nominal", 0, q.size(), t);
        check_lat("nominal", t, 49);
    endtask

    task automatic test_stalled_ad;
        int t;
        build(1, 4, 5, 0, 1);
        run("stalled_ad", 0, q.size(), t);
        check_lat("stalled_ad", t, 54);
    endtask

    task automatic test_ad2_pt1;
        int t;
        build(2, 1, 0, 0, 1);
        run("ad2_pt1", 1, q.size(), t);
        check_lat("ad2_pt1", t, 37);
    endtask

    task automatic test_random;
        int t, d;
        repeat (6) begin
            d = $urandom_range(0, 1);
            build(d ? 2 : 1, d ? 1 : 4, $urandom_range(0, 3), 3, 1);
            run("random", d, q.size(), t);
            check_lat("random", t, (d ? 37 : 49) + stall_sum);
        end
    endtask

    task automatic test_reset_mid;
        int t, stop;
        bit seen;
        build(1, 4, 0, 0, 0);
        stop = q.size();
        seen = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (seen && q[i].o[10:7] == 4'd5) begin
                stop = i + 1;
                break;
            end
            if (q[i].o[5]) seen = 1;
        end
        run("pre_reset", 0, stop, t);
        #2 rstb = 1'b0;
        #1 check_idle("async_reset");
        repeat (2) begin
            @(negedge clk);
            st0 = 1'b0;
            #1 check_idle("reset_mid_hold");
        end
        rstb = 1'b1;
        @(negedge clk);
        #1 check_idle("reset_mid_idle");
        build(1, 4, 0, 0, 0);
        run("after_reset", 0, q.size(), t);
        check_lat("after_reset", t, 49);
    endtask

`ifdef ASCON_ABORT_EN
    task automatic test_abort;
        int t;
        build(1, 4, 0, 0, 0);
        run("pre_abort", 0, 16, t);
        @(negedge clk);
        ab0 = 1'b1;
        #1 checks++;
        if (cv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle: cv %b busy %b, expected 0 1", cv0, busy0);
        end
        @(negedge clk);
        ab0 = 1'b0;
        v0 = 1'b0;
        #1 check_idle("abort_idle");
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_stalled_ad();
        test_ad2_pt1();
        test_random();
        test_reset_mid();
`ifdef ASCON_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ascon_ctrl.md
Name: ascon_ctrl

Overview:
- Sequencing FSM for the ASCON-128 encryption datapath: permutation round chain with input XOR, permutation rounds, output XOR and state register.
- Drives the round counter, the input- and output-XOR enables and selects, the state-init mux, and the per-block data handshake.
- Flags ciphertext and tag validity.
- Sits beside the datapath in the top level. It drives control only and carries no state data.

Parameters:
- NB_AD_BLOCKS, 1, number of 64-bit associated-data blocks; legal range 1..255.
- NB_PT_BLOCKS, 4, number of 64-bit plaintext blocks; legal range 1..255.

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- data_valid_i  in  1  upstream AD/PT block valid
- data_ready_o  out  1  controller accepts a block this cycle
- init_state_o  out  1  state mux selects IV||K||N instead of the state register
- ena_perm_o  out  1  state register loads the round-chain output
- round_o  out  4  round-constant index, 0..11
- ena_xor_up_o  out  1  XOR input data into the upper lanes
- sel_up_o  out  1  0 = data into x0; 1 = data into x0 and key into x1..x2
- ena_xor_down_o  out  1  XOR 256-bit word into lanes x1..x4
- sel_down_o  out  1  0 = 0^128||K; 1 = 0^255||1 (domain separation)
- cipher_valid_o  out  1  ciphertext block valid, combinational from x0^data
- tag_valid_o  out  1  tag valid on the registered state
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, and both counters clear. Reset mid-operation aborts immediately. No partial result is flagged.
- One permutation round per cycle. ena_perm_o=1 on every round cycle.
  - p12: round_o runs 0..11.
  - p6: round_o runs 6..11.
  - round_o wraps from 11 to the next phase start.
- States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FIN, DONE.
- IDLE:
  - start_i=1 moves to INIT. The first INIT cycle follows the start cycle.
  - start_i is ignored when busy_o=1.
- INIT (12 cycles):
  - Cycle round 0: init_state_o=1.
  - Round 11: ena_xor_down_o=1 with sel_down_o=0 (key).
  - Then go to AD_WAIT.
- AD_WAIT:
  - data_ready_o=1.
  - A transfer (valid & ready) is itself round 6: ena_xor_up_o=1, sel_up_o=0. Then go to AD_PERM for rounds 7..11.
  - With no valid, hold. round_o holds at 6 and ena_perm_o=0.
- AD_PERM:
  - On round 11 of the last AD block: ena_xor_down_o=1 with sel_down_o=1.
  - AD block counter increments at round 11.
  - At the end: if more AD blocks remain go to AD_WAIT, otherwise go to PT_WAIT.
- PT_WAIT:
  - data_ready_o=1. On transfer, cipher_valid_o=1 for that cycle only.
  - Non-last block: the transfer cycle is round 6 (ena_xor_up_o=1, sel_up_o=0), then go to PT_PERM for rounds 7..11, then back to PT_WAIT.
  - Last block: the transfer cycle is round 0 with ena_xor_up_o=1 and sel_up_o=1, then go to FIN.
- FIN:
  - Rounds 1..11.
  - Round 11: ena_xor_down_o=1 with sel_down_o=0, then go to DONE.
- DONE:
  - tag_valid_o=1 for exactly one cycle, then go to IDLE.
  - start_i in DONE is ignored.
- Counters: block counters are 8 bits and clear on entering INIT.
- Enables are mutually consistent. ena_xor_up_o and ena_xor_down_o are never both 1 except when a single block is also the last round; this does not occur for legal parameters.
- Latency with data_valid_i held 1: start cycle T gives tag_valid_o at T+1+12+6·NB_AD_BLOCKS+6·(NB_PT_BLOCKS−1)+12. Defaults give T+49.
- All outputs are Moore outputs except data_ready_o-qualified ones (cipher_valid_o and the transfer-cycle enables), which depend on data_valid_i.

Optional Feature:
- Macro: ASCON_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in any state except IDLE forces IDLE on the next edge. All outputs are 0 from that edge, and counters clear.
  - cipher_valid_o and tag_valid_o are masked to 0 in the abort cycle.
  - abort_i has priority over data transfer.
- Undefined: no abort_i port. Behaviour is exactly as above.

Test Plan:
- Reset then idle: resetb_i low for 3 cycles, start_i=0 → all outputs 0, busy_o=0, round_o=0.
- Nominal defaults, data_valid_i=1 constantly, start at T → init_state_o=1 at T+1; round_o 0..11 across T+1..T+12; xor_down key at T+12; 4 cipher_valid_o pulses at T+19, T+25, T+31, T+37; tag_valid_o at T+49 only.
- Stalled AD: data_valid_i low for 5 cycles in AD_WAIT → round_o holds 6, ena_perm_o=0, data_ready_o=1 throughout; a transfer in cycle 6 resumes; tag_valid_o delayed by exactly 5 cycles.
- NB_AD_BLOCKS=2, NB_PT_BLOCKS=1 → domain separation (sel_down_o=1) only on the second AD block's round 11; single PT transfer uses sel_up_o=1 at round 0; tag_valid_o at T+37.
- start_i pulsed during PT_PERM and again during DONE → ignored; no restart; returns to IDLE after the tag.
- Reset mid-FIN (round 5) → outputs 0 asynchronously, no tag_valid_o; the next start runs the full sequence. With ASCON_ABORT_EN, abort_i in AD_PERM gives IDLE next cycle and no cipher pulse.
